// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction/handshake inputs and datapath control outputs.
// master = control unit, slave = datapath side.
interface multicycle_control_unit_if;
    logic [15:0] inst;
    logic        mem_ready;
    logic        alu_zero;
    logic        pc_write;
    logic        pc_write_cond;
    logic        pc_src;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        reg_write;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        inst_done;
    logic        illegal_inst;
    logic        halted;
    logic [3:0]  state;

    modport master (
        input  inst, mem_ready, alu_zero,
        output pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write,
               iord, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               inst_done, illegal_inst, halted, state
    );

    modport slave (
        output inst, mem_ready, alu_zero,
        input  pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write,
               iord, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               inst_done, illegal_inst, halted, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM with fully registered outputs. Handshake-completion
// strobes (ir_write/pc_write after FETCH, inst_done after MEM_WR) are registered
// at the completing edge and therefore appear in the first cycle of the successor state.
module multicycle_control_unit (
    input  logic                         clock,
    input  logic                         reset,
    multicycle_control_unit_if.master    bus
);

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BR_TGT   = 4'd10,
        S_BR_CMP   = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  w_opcode;
    logic        w_illegal;
    logic        w_unused;

    logic        r_pc_write;
    logic        r_pc_write_cond;
    logic        r_pc_src;
    logic        r_ir_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_iord;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic        r_alu_src_a;
    logic [1:0]  r_alu_src_b;
    logic [1:0]  r_alu_op;
    logic        r_inst_done;
    logic        r_illegal_inst;
    logic        r_halted;

    assign w_opcode = bus.inst[3:0];
    assign w_unused = ^{bus.alu_zero, bus.inst[15:4]};

    // Next-state selection and undefined-opcode detection.
    always_comb begin
        w_next    = S_INIT;
        w_illegal = 1'b0;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_opcode)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4: w_next = S_EXEC_R;
                    4'h5, 4'h8, 4'h9, 4'hF:       w_next = S_EXEC_I;
                    4'hA, 4'hB:                   w_next = S_MEM_ADDR;
                    4'h6:                         w_next = S_BR_TGT;
                    4'h7:                         w_next = S_HALT;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
            S_MEM_ADDR: begin
                if (w_opcode == 4'hA) begin
                    w_next = S_MEM_RD;
                end else if (w_opcode == 4'hB) begin
                    w_next = S_MEM_WR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEM_RD: w_next = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: w_next = bus.mem_ready ? S_FETCH  : S_MEM_WR;
            S_WB_ALU, S_WB_MEM, S_BR_CMP: w_next = S_FETCH;
            S_BR_TGT: w_next = S_BR_CMP;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    // State register and registered outputs derived from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_INIT;
            r_pc_write      <= 1'b0;
            r_pc_write_cond <= 1'b0;
            r_pc_src        <= 1'b0;
            r_ir_write      <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_iord          <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_alu_src_a     <= 1'b0;
            r_alu_src_b     <= 2'b00;
            r_alu_op        <= 2'b00;
            r_inst_done     <= 1'b0;
            r_illegal_inst  <= 1'b0;
            r_halted        <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_pc_write      <= (r_state == S_FETCH) && bus.mem_ready;
            r_ir_write      <= (r_state == S_FETCH) && bus.mem_ready;
            r_inst_done     <= (r_state == S_MEM_WR) && bus.mem_ready;
            r_illegal_inst  <= w_illegal;
            r_pc_write_cond <= 1'b0;
            r_pc_src        <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_iord          <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_alu_src_a     <= 1'b0;
            r_alu_src_b     <= 2'b00;
            r_alu_op        <= 2'b00;
            r_halted        <= 1'b0;
            case (w_next)
                S_FETCH: begin
                    r_mem_read  <= 1'b1;
                    r_alu_src_b <= 2'b01;
                end
                S_EXEC_R: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_op    <= 2'b10;
                end
                S_EXEC_I: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= 2'b10;
                    r_alu_op    <= (w_opcode == 4'h5) ? 2'b11 : 2'b10;
                end
                S_MEM_ADDR: begin
                    r_alu_src_a <= 1'b1;
                    r_alu_src_b <= 2'b10;
                end
                S_MEM_RD: begin
                    r_mem_read <= 1'b1;
                    r_iord     <= 1'b1;
                end
                S_MEM_WR: begin
                    r_mem_write <= 1'b1;
                    r_iord      <= 1'b1;
                end
                S_WB_ALU: begin
                    r_reg_write <= 1'b1;
                    r_inst_done <= 1'b1;
                end
                S_WB_MEM: begin
                    r_reg_write  <= 1'b1;
                    r_mem_to_reg <= 1'b1;
                    r_inst_done  <= 1'b1;
                end
                // Branch target is PC+2 + (imm<<1); the compare leaves PC gating to alu_zero in the datapath.
                S_BR_TGT: begin
                    r_alu_src_b <= 2'b10;
                end
                S_BR_CMP: begin
                    r_alu_src_a     <= 1'b1;
                    r_alu_op        <= 2'b01;
                    r_pc_write_cond <= 1'b1;
                    r_pc_src        <= 1'b1;
                    r_inst_done     <= 1'b1;
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.pc_write      = r_pc_write;
    assign bus.pc_write_cond = r_pc_write_cond;
    assign bus.pc_src        = r_pc_src;
    assign bus.ir_write      = r_ir_write;
    assign bus.mem_read      = r_mem_read;
    assign bus.mem_write     = r_mem_write;
    assign bus.iord          = r_iord;
    assign bus.reg_write     = r_reg_write;
    assign bus.mem_to_reg    = r_mem_to_reg;
    assign bus.alu_src_a     = r_alu_src_a;
    assign bus.alu_src_b     = r_alu_src_b;
    assign bus.alu_op        = r_alu_op;
    assign bus.inst_done     = r_inst_done;
    assign bus.illegal_inst  = r_illegal_inst;
    assign bus.halted        = r_halted;
    assign bus.state         = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: every output packed into one word
// {state, pcw, pcwc, pcs, irw, mrd, mwr, iord, rw, m2r, asa, asb, aop, done, ill, halt}.
module tb_multicycle_control_unit;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    multicycle_control_unit_if bus();

    multicycle_control_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [20:0] W_INIT       = {4'd0,  9'b000000000, 1'b0, 2'b00, 2'b00, 3'b000};
    localparam logic [20:0] W_FETCH      = {4'd1,  9'b000010000, 1'b0, 2'b01, 2'b00, 3'b000};
    localparam logic [20:0] W_FETCH_DONE = {4'd1,  9'b000010000, 1'b0, 2'b01, 2'b00, 3'b100};
    localparam logic [20:0] W_FETCH_ILL  = {4'd1,  9'b000010000, 1'b0, 2'b01, 2'b00, 3'b010};
    localparam logic [20:0] W_DEC        = {4'd2,  9'b100100000, 1'b0, 2'b00, 2'b00, 3'b000};
    localparam logic [20:0] W_EXR        = {4'd3,  9'b000000000, 1'b1, 2'b00, 2'b10, 3'b000};
    localparam logic [20:0] W_EXI_B      = {4'd4,  9'b000000000, 1'b1, 2'b10, 2'b11, 3'b000};
    localparam logic [20:0] W_EXI_O      = {4'd4,  9'b000000000, 1'b1, 2'b10, 2'b10, 3'b000};
    localparam logic [20:0] W_MADDR      = {4'd5,  9'b000000000, 1'b1, 2'b10, 2'b00, 3'b000};
    localparam logic [20:0] W_MRD        = {4'd6,  9'b000010100, 1'b0, 2'b00, 2'b00, 3'b000};
    localparam logic [20:0] W_MWR        = {4'd7,  9'b000001100, 1'b0, 2'b00, 2'b00, 3'b000};
    localparam logic [20:0] W_WBALU      = {4'd8,  9'b000000010, 1'b0, 2'b00, 2'b00, 3'b100};
    localparam logic [20:0] W_WBMEM      = {4'd9,  9'b000000011, 1'b0, 2'b00, 2'b00, 3'b100};
    localparam logic [20:0] W_BRT        = {4'd10, 9'b000000000, 1'b0, 2'b10, 2'b00, 3'b000};
    localparam logic [20:0] W_BRC        = {4'd11, 9'b011000000, 1'b1, 2'b00, 2'b01, 3'b100};
    localparam logic [20:0] W_HALT       = {4'd12, 9'b000000000, 1'b0, 2'b00, 2'b00, 3'b001};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [20:0] obs();
        return {bus.state, bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.ir_write,
                bus.mem_read, bus.mem_write, bus.iord, bus.reg_write, bus.mem_to_reg,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.inst_done,
                bus.illegal_inst, bus.halted};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.mem_ready = 1'b0; bus.inst = 16'h0000;
        tick(); n_cmp++;
        if (obs() !== W_INIT) begin n_err++; $display("FAIL reset_init: got %h expected %h", obs(), W_INIT); end
        bus.mem_ready = 1'b1; bus.inst = 16'h000B;
        tick(); n_cmp++;
        if (obs() !== W_INIT) begin n_err++; $display("FAIL reset_priority: got %h expected %h", obs(), W_INIT); end
        reset = 1'b0;
        tick(); n_cmp++;
        if (obs() !== W_FETCH) begin n_err++; $display("FAIL reset_to_fetch: got %h expected %h", obs(), W_FETCH); end
    endtask

    task automatic test_rtype();
        logic [20:0] e [4] = '{W_DEC, W_EXR, W_WBALU, W_FETCH};
        bus.inst = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1; tick(); n_cmp++;
            if (obs() !== e[i]) begin n_err++; $display("FAIL rtype step %0d: got %h expected %h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_fetch_wait();
        logic [20:0] e [6] = '{W_FETCH, W_FETCH, W_DEC, W_EXI_O, W_WBALU, W_FETCH};
        bit          r [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bus.inst = 16'h1238;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = r[i]; tick(); n_cmp++;
            if (obs() !== e[i]) begin n_err++; $display("FAIL fetch_wait step %0d: got %h expected %h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_itype();
        logic [20:0] e [8] = '{W_DEC, W_EXI_B, W_WBALU, W_FETCH, W_DEC, W_EXI_O, W_WBALU, W_FETCH};
        for (int i = 0; i < 8; i++) begin
            bus.inst = (i < 4) ? 16'hABC5 : 16'h004F;
            bus.mem_ready = 1'b1; tick(); n_cmp++;
            if (obs() !== e[i]) begin n_err++; $display("FAIL itype step %0d: got %h expected %h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_load_wait();
        logic [20:0] e [8] = '{W_DEC, W_MADDR, W_MRD, W_MRD, W_MRD, W_MRD, W_WBMEM, W_FETCH};
        bit          r [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.inst = 16'h001A;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = r[i]; tick(); n_cmp++;
            if (obs() !== e[i]) begin n_err++; $display("FAIL load_wait step %0d: got %h expected %h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_store();
        logic [20:0] e [6] = '{W_DEC, W_MADDR, W_MWR, W_MWR, W_FETCH_DONE, W_FETCH};
        bit          r [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        bus.inst = 16'h002B;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = r[i]; tick(); n_cmp++;
            if (obs() !== e[i]) begin n_err++; $display("FAIL store step %0d: got %h expected %h", i, obs(), e[i]); end
        end
    endtask

    task automatic test_branch();
        logic [20:0] e [4] = '{W_DEC, W_BRT, W_BRC, W_FETCH};
        bus.inst = 16'hFF06; bus.alu_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1; tick(); n_cmp++;
            if (obs() !== e[i]) begin n_err++; $display("FAIL branch step %0d: got %h expected %h", i, obs(), e[i]); end
        end
        bus.alu_zero = 1'b0;
    endtask

    task automatic test_illegal();
        logic [20:0] e [4] = '{W_DEC, W_FETCH_ILL, W_FETCH, W_FETCH};
        bit          r [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        bus.inst = 16'h000D;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = r[i]; tick(); n_cmp++;
            if (obs() !== e[i]) begin n_err++; $display("FAIL illegal step %0d: got %h expected %h", i, obs(), e[i]); end
        end
    endtask

    // Decode successor for boundary opcodes, each followed by a reset from that state.
    task automatic test_decode_table();
        logic [3:0]  op [10] = '{4'h4, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 4'h6, 4'h7};
        logic [20:0] e  [10] = '{W_EXR, W_EXR, W_EXI_O, W_EXI_O, W_MADDR, W_MADDR,
                                 W_FETCH_ILL, W_FETCH_ILL, W_BRT, W_HALT};
        for (int i = 0; i < 10; i++) begin
            bus.inst = {12'h5A5, op[i]}; bus.mem_ready = 1'b1;
            tick(); n_cmp++;
            if (obs() !== W_DEC) begin n_err++; $display("FAIL decode_tbl %0d dec: got %h expected %h", i, obs(), W_DEC); end
            tick(); n_cmp++;
            if (obs() !== e[i]) begin n_err++; $display("FAIL decode_tbl %0d succ: got %h expected %h", i, obs(), e[i]); end
            reset = 1'b1; tick(); n_cmp++;
            if (obs() !== W_INIT) begin n_err++; $display("FAIL decode_tbl %0d rst: got %h expected %h", i, obs(), W_INIT); end
            reset = 1'b0; tick(); n_cmp++;
            if (obs() !== W_FETCH) begin n_err++; $display("FAIL decode_tbl %0d fetch: got %h expected %h", i, obs(), W_FETCH); end
        end
    endtask

    task automatic test_halt();
        bus.inst = 16'h0007; bus.mem_ready = 1'b1;
        tick(); n_cmp++;
        if (obs() !== W_DEC) begin n_err++; $display("FAIL halt_dec: got %h expected %h", obs(), W_DEC); end
        for (int i = 0; i < 12; i++) begin
            tick(); n_cmp++;
            if (obs() !== W_HALT) begin n_err++; $display("FAIL halt_hold %0d: got %h expected %h", i, obs(), W_HALT); end
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.inst      = 16'($urandom_range(0, 65535));
        end
        reset = 1'b1; tick(); n_cmp++;
        if (obs() !== W_INIT) begin n_err++; $display("FAIL halt_reset: got %h expected %h", obs(), W_INIT); end
        reset = 1'b0; tick(); n_cmp++;
        if (obs() !== W_FETCH) begin n_err++; $display("FAIL halt_refetch: got %h expected %h", obs(), W_FETCH); end
    endtask

    task automatic test_reset_mid();
        logic [20:0] e [3] = '{W_DEC, W_MADDR, W_MWR};
        bus.inst = 16'h000B;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b1; tick(); n_cmp++;
            if (obs() !== e[i]) begin n_err++; $display("FAIL rst_mwr step %0d: got %h expected %h", i, obs(), e[i]); end
        end
        bus.mem_ready = 1'b1; reset = 1'b1; tick(); n_cmp++;
        if (obs() !== W_INIT) begin n_err++; $display("FAIL rst_mwr_init: got %h expected %h", obs(), W_INIT); end
        reset = 1'b0; tick(); n_cmp++;
        if (obs() !== W_FETCH) begin n_err++; $display("FAIL rst_mwr_fetch: got %h expected %h", obs(), W_FETCH); end
        bus.inst = 16'h000A; bus.mem_ready = 1'b1; tick(); tick();
        bus.mem_ready = 1'b0; tick(); n_cmp++;
        if (obs() !== W_MRD) begin n_err++; $display("FAIL rst_mrd_pre: got %h expected %h", obs(), W_MRD); end
        bus.mem_ready = 1'b1; reset = 1'b1; tick(); n_cmp++;
        if (obs() !== W_INIT) begin n_err++; $display("FAIL rst_mrd_init: got %h expected %h", obs(), W_INIT); end
        reset = 1'b0; tick(); n_cmp++;
        if (obs() !== W_FETCH) begin n_err++; $display("FAIL rst_mrd_fetch: got %h expected %h", obs(), W_FETCH); end
        bus.mem_ready = 1'b1; reset = 1'b1; tick(); n_cmp++;
        if (obs() !== W_INIT) begin n_err++; $display("FAIL rst_fetch_init: got %h expected %h", obs(), W_INIT); end
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.inst = 16'h0000;
        bus.mem_ready = 1'b0;
        bus.alu_zero = 1'b0;
        test_reset();
        test_rtype();
        test_fetch_wait();
        test_itype();
        test_load_wait();
        test_store();
        test_branch();
        test_illegal();
        test_decode_table();
        test_halt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
